// File: rtl/if_id_pkg.sv
// Shared types and constants for the fetch/decode boundary.
// The fetch triple travels as one packed record through the buffer.
package if_id_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] instr;
        logic [15:0] pc;
        logic [15:0] pc_plus4;
    } fetch_pkt_t;

endpackage

// File: rtl/sync_fifo_flush.sv
// Circular FIFO of fetch triples with push/pop and a single-cycle flush.
// Flush wins over push and pop: the queue is emptied and rd_ptr jumps to wr_ptr.
module sync_fifo_flush
    import if_id_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  fetch_pkt_t       wr_data,
    output fetch_pkt_t       rd_data,
    output logic [CNT_W-1:0] count
);

    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             wr_en;
    fetch_pkt_t       mem_q [DEPTH];

    // NOTE: every signal gets its hold value first, so no path leaves it unassigned (no latch).
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        wr_en    = push & ~flush;
        if (flush) begin
            count_d  = '0;
            rd_ptr_d = wr_ptr_q;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: storage has no reset; the consumer only reads it while count is non-zero.
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr_q] <= wr_data;
    end

    assign rd_data = mem_q[rd_ptr_q];
    assign count   = count_q;

endmodule

// File: rtl/if_id_buffer.sv
// IF/ID decoupling buffer: queues fetch triples, stalls fetch when full,
// drops wrong-path work on a redirect and shows a NOP to decode when empty.
module if_id_buffer
    import if_id_pkg::fetch_pkt_t;
#(
    parameter int          DEPTH     = 2,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] if_instr,
    input  logic [15:0] if_pc,
    input  logic [15:0] if_pc_plus4,
    input  logic        pc_src,
    input  logic        id_ready,
    output logic        id_valid,
    output logic [31:0] id_instr,
    output logic [15:0] id_pc,
    output logic [15:0] id_pc_plus4,
    output logic        pc_write_zero
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    fetch_pkt_t       wr_pkt;
    fetch_pkt_t       head_pkt;
    logic [CNT_W-1:0] count;
    logic             has_data;
    logic             pop;
    logic             push;

    sync_fifo_flush #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (push),
        .pop     (pop),
        .flush   (pc_src),
        .wr_data (wr_pkt),
        .rd_data (head_pkt),
        .count   (count)
    );

    // A pop frees the slot this cycle, so a full buffer being drained keeps fetch running.
    always_comb begin
        has_data      = (count != '0);
        pop           = has_data & id_ready;
        pc_write_zero = (count == CNT_W'(DEPTH)) & ~pop;
        push          = ~pc_write_zero & ~pc_src;
        wr_pkt        = '{instr: if_instr, pc: if_pc, pc_plus4: if_pc_plus4};

        id_valid    = has_data;
        id_instr    = NOP_INSTR;
        id_pc       = '0;
        id_pc_plus4 = '0;
        if (has_data) begin
            id_instr    = head_pkt.instr;
            id_pc       = head_pkt.pc;
            id_pc_plus4 = head_pkt.pc_plus4;
        end
    end

endmodule

// File: tb/tb_if_id_buffer.sv
// Bench for if_id_buffer: directed vector table, async-reset sequence,
// then randomized fetch/decode traffic against a queue-based reference model.
module tb_if_id_buffer;
    import if_id_pkg::*;

    localparam int          DEPTH = 2;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] if_instr;
    logic [15:0] if_pc;
    logic [15:0] if_pc_plus4;
    logic        pc_src;
    logic        id_ready;
    logic        id_valid;
    logic [31:0] id_instr;
    logic [15:0] id_pc;
    logic [15:0] id_pc_plus4;
    logic        pc_write_zero;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    if_id_buffer #(.DEPTH(DEPTH), .NOP_INSTR(NOP)) dut (
        .clk           (clk),
        .reset         (reset),
        .if_instr      (if_instr),
        .if_pc         (if_pc),
        .if_pc_plus4   (if_pc_plus4),
        .pc_src        (pc_src),
        .id_ready      (id_ready),
        .id_valid      (id_valid),
        .id_instr      (id_instr),
        .id_pc         (id_pc),
        .id_pc_plus4   (id_pc_plus4),
        .pc_write_zero (pc_write_zero)
    );

    typedef struct {
        logic [15:0] pc;
        logic        src;
        logic        rdy;
        logic        exp_valid;
        logic [31:0] exp_instr;
        logic [15:0] exp_pc;
        logic [15:0] exp_pc4;
        logic        exp_pwz;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [31:0] mk_instr(input logic [15:0] pc);
        return {16'hC0DE, pc};
    endfunction

    // One row: fetch presents pc (instr and pc+4 derived), expected head is epc or empty.
    function automatic void add(input logic [15:0] pc, input logic src, input logic rdy,
                                input logic ev, input logic [15:0] epc, input logic epwz);
        vec_t v;
        v.pc        = pc;
        v.src       = src;
        v.rdy       = rdy;
        v.exp_valid = ev;
        v.exp_instr = ev ? mk_instr(epc) : NOP;
        v.exp_pc    = ev ? epc : 16'h0;
        v.exp_pc4   = ev ? epc + 16'd4 : 16'h0;
        v.exp_pwz   = epwz;
        vecs.push_back(v);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_outs(input string tag, input logic ev, input logic [31:0] ei,
                              input logic [15:0] ep, input logic [15:0] ep4, input logic epwz);
        check({tag, ".id_valid"},      32'(id_valid),      32'(ev));
        check({tag, ".id_instr"},      id_instr,           ei);
        check({tag, ".id_pc"},         32'(id_pc),         32'(ep));
        check({tag, ".id_pc_plus4"},   32'(id_pc_plus4),   32'(ep4));
        check({tag, ".pc_write_zero"}, 32'(pc_write_zero), 32'(epwz));
    endtask

    task automatic drive(input logic [31:0] i, input logic [15:0] p, input logic [15:0] p4,
                         input logic src, input logic rdy);
        if_instr    = i;
        if_pc       = p;
        if_pc_plus4 = p4;
        pc_src      = src;
        id_ready    = rdy;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    fetch_pkt_t model_q[$];
    fetch_pkt_t cur;

    initial begin
        reset = 1'b1;
        drive(32'h0, 16'h0, 16'h0, 1'b0, 1'b0);
        #2;
        check_outs("reset_state", 1'b0, NOP, 16'h0, 16'h0, 1'b0);
        next_cycle();
        next_cycle();
        reset = 1'b0;

        // Streaming, backpressure with a held triple, full+pop, flushes.
        add(16'h0000, 0, 1, 0, 16'h0000, 0);
        add(16'h0004, 0, 1, 1, 16'h0000, 0);
        add(16'h0008, 0, 1, 1, 16'h0004, 0);
        add(16'h0010, 0, 1, 1, 16'h0008, 0);
        add(16'h0014, 0, 0, 1, 16'h0010, 0);
        add(16'h0018, 0, 0, 1, 16'h0010, 1);
        add(16'h0018, 0, 0, 1, 16'h0010, 1);
        add(16'h0018, 0, 0, 1, 16'h0010, 1);
        add(16'h0018, 0, 1, 1, 16'h0010, 0);
        add(16'h001C, 0, 0, 1, 16'h0014, 1);
        add(16'h001C, 0, 1, 1, 16'h0014, 0);
        add(16'h0020, 0, 1, 1, 16'h0018, 0);
        add(16'h0030, 0, 1, 1, 16'h001C, 0);
        add(16'h0034, 0, 1, 1, 16'h0020, 0);
        add(16'h0038, 1, 1, 1, 16'h0030, 0);
        add(16'h0100, 0, 1, 0, 16'h0000, 0);
        add(16'h0104, 0, 1, 1, 16'h0100, 0);
        add(16'h0108, 1, 0, 1, 16'h0104, 0);
        add(16'h0200, 0, 0, 0, 16'h0000, 0);
        add(16'h0204, 0, 0, 1, 16'h0200, 0);
        add(16'h0208, 1, 0, 1, 16'h0200, 1);
        add(16'h0300, 0, 0, 0, 16'h0000, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            drive(mk_instr(vecs[i].pc), vecs[i].pc, vecs[i].pc + 16'd4, vecs[i].src, vecs[i].rdy);
            #1;
            check_outs($sformatf("vec%0d", i), vecs[i].exp_valid, vecs[i].exp_instr,
                       vecs[i].exp_pc, vecs[i].exp_pc4, vecs[i].exp_pwz);
            next_cycle();
        end

        // Fill to two entries, then assert reset mid-cycle with no clock edge.
        drive(mk_instr(16'h0400), 16'h0400, 16'h0404, 1'b0, 1'b0);
        #1;
        check_outs("pre_rst_a", 1'b1, mk_instr(16'h0300), 16'h0300, 16'h0304, 1'b0);
        next_cycle();
        drive(mk_instr(16'h0404), 16'h0404, 16'h0408, 1'b0, 1'b0);
        #1;
        check_outs("pre_rst_b", 1'b1, mk_instr(16'h0300), 16'h0300, 16'h0304, 1'b1);
        #2;
        reset = 1'b1;
        #1;
        check_outs("async_rst", 1'b0, NOP, 16'h0, 16'h0, 1'b0);
        next_cycle();
        reset = 1'b0;
        drive(mk_instr(16'h0500), 16'h0500, 16'h0504, 1'b0, 1'b0);
        #1;
        check_outs("post_rst_empty", 1'b0, NOP, 16'h0, 16'h0, 1'b0);
        next_cycle();
        drive(mk_instr(16'h0504), 16'h0504, 16'h0508, 1'b1, 1'b0);
        #1;
        check_outs("post_rst_first", 1'b1, mk_instr(16'h0500), 16'h0500, 16'h0504, 1'b0);
        next_cycle();

        // Randomized traffic: bench acts as fetch (holds on stall) and checks against a queue model.
        model_q.delete();
        cur = '{instr: $urandom, pc: 16'h1000, pc_plus4: 16'h1004};
        for (int n = 0; n < 600; n++) begin
            logic rdy, src, m_valid, m_pop, m_pwz;
            fetch_pkt_t head;
            rdy = ($urandom_range(0, 3) != 0) ^ (n[5] & n[3]);
            src = ($urandom_range(0, 11) == 0);
            drive(cur.instr, cur.pc, cur.pc_plus4, src, rdy);
            #1;
            m_valid = (model_q.size() != 0);
            m_pop   = m_valid && rdy;
            m_pwz   = (model_q.size() == DEPTH) && !m_pop;
            head    = m_valid ? model_q[0] : '{instr: NOP, pc: 16'h0, pc_plus4: 16'h0};
            check_outs($sformatf("rand%0d", n), m_valid, head.instr, head.pc, head.pc_plus4, m_pwz);
            if (src) begin
                model_q.delete();
            end else begin
                if (m_pop) model_q.delete(0);
                if (!m_pwz) model_q.push_back(cur);
            end
            if (src) begin
                cur.pc       = 16'($urandom) & 16'hFFFC;
                cur.pc_plus4 = cur.pc + 16'd4;
                cur.instr    = $urandom;
            end else if (!m_pwz) begin
                cur.pc       = cur.pc + 16'd4;
                cur.pc_plus4 = cur.pc + 16'd4;
                cur.instr    = $urandom;
            end
            next_cycle();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/if_id_buffer.md
Name: if_id_buffer

Overview:
- Consumer end of the fetch interface: captures each fetched triple (instr, pc, pc_plus4) into a small FIFO and presents it to decode with a valid/ready handshake.
- Generates pc_write_zero back to fetch to hold the PC when the buffer cannot accept.
- Flushes wrong-path entries on a taken redirect (pc_src).
- Sits between the fetch stage and the decode stage.

Parameters:
- DEPTH, 2, number of buffered fetch triples (power of two, ≥2).
- NOP_INSTR, 32'h0000_0013, value driven on id_instr whenever id_valid=0.

Ports:
- clk  input  1  clock, all state on rising edge.
- reset  input  1  asynchronous, active-high reset.
- if_instr  input  32  instruction currently presented by fetch.
- if_pc  input  16  PC of if_instr.
- if_pc_plus4  input  16  if_pc+4 from fetch.
- pc_src  input  1  redirect taken this cycle; current fetch triple and all buffered entries are wrong-path.
- id_ready  input  1  decode accepts head entry this cycle.
- id_valid  output  1  head entry valid.
- id_instr  output  32  head instruction, NOP_INSTR when empty.
- id_pc  output  16  head PC, 0 when empty.
- id_pc_plus4  output  16  head PC+4, 0 when empty.
- pc_write_zero  output  1  1 = fetch must hold PC (no new triple next cycle).

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-high (reset).
- Storage: circular FIFO, rd_ptr/wr_ptr of $clog2(DEPTH) bits wrapping modulo DEPTH; count of $clog2(DEPTH)+1 bits.
- Reset (async, any time incl. mid-operation):
  - count=0, pointers=0, id_valid=0, id_instr=NOP_INSTR, id_pc=0, id_pc_plus4=0, pc_write_zero=0.
  - Storage contents need no reset.
- pop = id_valid & id_ready.
- pc_write_zero (combinational) = (count==DEPTH) & ~pop.
- push = ~pc_write_zero & ~pc_src.
  - Every non-held, non-redirect cycle captures the fetch triple.
  - A held cycle never captures, so a repeated triple is not duplicated.
- Update:
  - push & ~pop: count+1.
  - pop & ~push: count−1.
  - both: count unchanged, both pointers advance; legal when full, because pop frees the slot.
- Flush:
  - pc_src=1: next cycle count=0 and rd_ptr=wr_ptr; current triple is dropped.
  - Flush beats a simultaneous pop: the head is still considered consumed by decode, but no residual entry remains.
  - Flush beats a simultaneous push.
  - pc_write_zero is still computed normally in a flush cycle.
- Output timing:
  - Outputs come from the head entry; id_valid = (count!=0); first-word latency is 1 cycle (push at edge N, id_valid=1 after edge N).
  - When empty, output the NOP/zero values; never stale data.
- Data width: PC fields are stored verbatim; no arithmetic on pc_plus4 (16-bit wrap is fetch's responsibility).
- Invariants:
  - count never exceeds DEPTH.
  - Never pop when empty (id_valid gates pop).

Decomposition:
- Shared package if_id_pkg:
  - typedef fetch_pkt_t {instr[31:0], pc[15:0], pc_plus4[15:0]}.
  - localparam NOP_INSTR.
- One natural sub-module: sync_fifo_flush. It is a generic DEPTH×fetch_pkt_t FIFO with push/pop/flush/count.
- if_id_buffer wraps it with the stall and NOP logic.

Test Plan:
- Reset: assert reset mid-stream with count=2 → outputs immediately become id_valid=0, id_instr=32'h13, pc_write_zero=0, asynchronously without a clock edge.
- Streaming: id_ready=1, pc 0x0000,0x0004,0x0008 with instrs A,B,C → id_valid rises 1 cycle after each push; id outputs A/0x0000/0x0004 then B, C in order; pc_write_zero never asserts.
- Backpressure:
  - id_ready=0, push 0x0010 and 0x0014 → count=2, pc_write_zero=1.
  - Triple 0x0018 held 3 cycles → captured once only after id_ready=1; output order 0x10, 0x14, 0x18.
- Full plus simultaneous pop: count=2, id_ready=1, new triple 0x0020 → pc_write_zero=0, count stays 2, head advances.
- Flush:
  - count=2 (0x30, 0x34), pc_src=1 with triple 0x38 and id_ready=1 → next cycle id_valid=0, id_instr=32'h13.
  - Following triple 0x0100 → appears 1 cycle later.
- Pointer wrap: 10 push/pop cycles alternating stall patterns → output sequence matches input order exactly, with no loss and no duplication across the wrap.
